// File: rtl/snake_body.sv
// Snake body register file: 128-entry shift chain of 4-bit (x,y) segments with IDLE/RUN/DEAD control.
// Define SNAKE_WRAP_EN to wrap the head around the 16x16 field instead of dying at the border.
module snake_body #(
  parameter int         INIT_LEN = 3,
  parameter logic [3:0] START_X  = 4'd7,
  parameter logic [3:0] START_Y  = 4'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic [1:0] dir,
  input  logic       grow,
  input  logic       collision,
  output logic [3:0] head_x,
  output logic [3:0] head_y,
  output logic [3:0] x [0:127],
  output logic [3:0] y [0:127],
  output logic [7:0] snake_length,
  output logic       alive,
  output logic       moved
);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;

  state_t     state, state_nx;
  logic [1:0] heading, last_dir, ref_dir;
  logic       grow_pending;
  logic [4:0] nx5, ny5;
  logic       border, do_move, do_init, reversal;

  assign head_x = x[0];
  assign head_y = y[0];

  // One extra bit on the candidate head exposes under/overflow of the 0..15 field.
  always_comb begin
    nx5 = {1'b0, x[0]};
    ny5 = {1'b0, y[0]};
    case (heading)
      DIR_UP:    ny5 = {1'b0, y[0]} - 5'd1;
      DIR_RIGHT: nx5 = {1'b0, x[0]} + 5'd1;
      DIR_DOWN:  ny5 = {1'b0, y[0]} + 5'd1;
      default:   nx5 = {1'b0, x[0]} - 5'd1;
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign border = 1'b0;
`else
  assign border = nx5[4] | ny5[4];
`endif

  always_comb begin
    state_nx = state;
    do_move  = 1'b0;
    do_init  = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        if (collision)   state_nx = DEAD;
        else if (tick) begin
          if (border)    state_nx = DEAD;
          else           do_move  = 1'b1;
        end
      end
      DEAD: if (start) begin
        state_nx = IDLE;
        do_init  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // On a move edge the heading being applied becomes the one a reversal is judged against.
  assign ref_dir  = do_move ? heading : last_dir;
  assign reversal = (dir == (ref_dir ^ 2'b10));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      heading      <= DIR_RIGHT;
      last_dir     <= DIR_RIGHT;
      grow_pending <= 1'b0;
      snake_length <= 8'(INIT_LEN);
      alive        <= 1'b0;
      moved        <= 1'b0;
      for (int i = 0; i < 128; i++) begin
        x[i] <= START_X - 4'(i);
        y[i] <= START_Y;
      end
    end else begin
      state <= state_nx;
      alive <= (state_nx == RUN);
      moved <= do_move;
      if (do_init) begin
        heading      <= DIR_RIGHT;
        last_dir     <= DIR_RIGHT;
        grow_pending <= 1'b0;
        snake_length <= 8'(INIT_LEN);
        for (int i = 0; i < 128; i++) begin
          x[i] <= START_X - 4'(i);
          y[i] <= START_Y;
        end
      end else begin
        if (state == RUN && !reversal) heading <= dir;
        if (do_move) last_dir <= heading;
        if (state != DEAD && grow) grow_pending <= 1'b1;
        else if (do_move)          grow_pending <= 1'b0;
        if (do_move && grow_pending && snake_length != 8'd128)
          snake_length <= snake_length + 8'd1;
        if (do_move) begin
          for (int i = 1; i < 128; i++) begin
            x[i] <= x[i-1];
            y[i] <= y[i-1];
          end
          x[0] <= nx5[3:0];
          y[0] <= ny5[3:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_body.sv
// Scoreboarded bench for snake_body: a reference model pushes the expected head/length per tick,
// popped and compared when moved pulses.
module tb_snake_body;
  logic       clk = 1'b0;
  logic       rst, start, tick, grow, collision;
  logic [1:0] dir;
  logic [3:0] head_x, head_y;
  logic [3:0] x [0:127];
  logic [3:0] y [0:127];
  logic [7:0] snake_length;
  logic       alive, moved;

  snake_body dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .dir(dir), .grow(grow),
    .collision(collision), .head_x(head_x), .head_y(head_y), .x(x), .y(y),
    .snake_length(snake_length), .alive(alive), .moved(moved)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] hx; logic [3:0] hy; logic [7:0] len; } exp_t;
  exp_t sb[$];
  exp_t e;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [3:0] mx [0:127];
  logic [3:0] my [0:127];
  int         mlen;
  logic [1:0] mhead, mlast;
  bit         mpend;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic s, input logic t, input logic g, input logic c);
    start = s; tick = t; grow = g; collision = c;
    cyc();
    start = 0; tick = 0; grow = 0; collision = 0;
  endtask

  task automatic model_init();
    for (int i = 0; i < 128; i++) begin
      mx[i] = 4'(7 - i);
      my[i] = 4'd7;
    end
    mlen = 3; mhead = 2'b01; mlast = 2'b01; mpend = 0;
  endtask

  // Present a heading request (optionally with a grow pulse) for one cycle.
  task automatic set_dir(input logic [1:0] d, input logic g);
    dir = d;
    if (d != (mlast ^ 2'b10)) mhead = d;
    if (g) mpend = 1;
    strobe(0, 0, g, 0);
  endtask

  task automatic push_tick();
    logic [3:0] nxv, nyv;
    exp_t p;
    nxv = mx[0]; nyv = my[0];
    case (mhead)
      2'b00: nyv = nyv - 4'd1;
      2'b01: nxv = nxv + 4'd1;
      2'b10: nyv = nyv + 4'd1;
      default: nxv = nxv - 4'd1;
    endcase
    for (int i = 127; i > 0; i--) begin
      mx[i] = mx[i-1];
      my[i] = my[i-1];
    end
    mx[0] = nxv; my[0] = nyv;
    if (mpend) begin
      if (mlen < 128) mlen++;
      mpend = 0;
    end
    mlast = mhead;
    p.hx = nxv; p.hy = nyv; p.len = 8'(mlen);
    sb.push_back(p);
    strobe(0, 1, 0, 0);
  endtask

  task automatic await_move(output bit got);
    int n = 0;
    while (moved !== 1'b1 && n < 4) begin
      cyc();
      n++;
    end
    got = (moved === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; tick = 0; grow = 0; collision = 0; dir = 2'b01;
    cyc(); cyc();
    chk_cnt++; if (head_x !== 4'd7) $display("FAIL reset_hx got %0d want 7", head_x); else pass_cnt++;
    chk_cnt++; if (head_y !== 4'd7) $display("FAIL reset_hy got %0d want 7", head_y); else pass_cnt++;
    chk_cnt++; if (x[1] !== 4'd6) $display("FAIL reset_x1 got %0d want 6", x[1]); else pass_cnt++;
    chk_cnt++; if (x[2] !== 4'd5) $display("FAIL reset_x2 got %0d want 5", x[2]); else pass_cnt++;
    chk_cnt++; if (snake_length !== 8'd3) $display("FAIL reset_len got %0d want 3", snake_length); else pass_cnt++;
    chk_cnt++; if (alive !== 1'b0) $display("FAIL reset_alive got %b want 0", alive); else pass_cnt++;
    chk_cnt++; if (moved !== 1'b0) $display("FAIL reset_moved got %b want 0", moved); else pass_cnt++;
    rst = 0;
    model_init();
    strobe(0, 1, 0, 0);
    chk_cnt++; if (head_x !== 4'd7 || alive !== 1'b0) $display("FAIL idle_tick got x=%0d alive=%b want 7/0", head_x, alive); else pass_cnt++;
  endtask

  task automatic test_start();
    bit got;
    strobe(1, 0, 0, 0);
    chk_cnt++; if (alive !== 1'b1) $display("FAIL start_alive got %b want 1", alive); else pass_cnt++;
    set_dir(2'b01, 0);
    push_tick();
    await_move(got);
    chk_cnt++; if (!got) $display("FAIL start_moved got 0 want 1"); else pass_cnt++;
    e = sb.pop_front();
    chk_cnt++; if ({head_x, head_y, snake_length} !== {e.hx, e.hy, e.len})
      $display("FAIL start_head got (%0d,%0d) len %0d want (%0d,%0d) len %0d", head_x, head_y, snake_length, e.hx, e.hy, e.len);
    else pass_cnt++;
    chk_cnt++; if (head_x !== 4'd8) $display("FAIL start_hx got %0d want 8", head_x); else pass_cnt++;
    cyc();
    chk_cnt++; if (moved !== 1'b0) $display("FAIL moved_one_cycle got %b want 0", moved); else pass_cnt++;
  endtask

  task automatic test_reversal();
    bit got;
    set_dir(2'b11, 0);
    push_tick();
    await_move(got);
    e = sb.pop_front();
    chk_cnt++; if (!got || head_x !== e.hx || head_y !== e.hy)
      $display("FAIL rev_reject got (%0d,%0d) want (%0d,%0d)", head_x, head_y, e.hx, e.hy);
    else pass_cnt++;
    chk_cnt++; if (head_x !== 4'd9) $display("FAIL rev_reject_x got %0d want 9", head_x); else pass_cnt++;
    set_dir(2'b00, 0);
    push_tick();
    await_move(got);
    e = sb.pop_front();
    chk_cnt++; if (!got || head_x !== e.hx || head_y !== e.hy)
      $display("FAIL turn_up got (%0d,%0d) want (%0d,%0d)", head_x, head_y, e.hx, e.hy);
    else pass_cnt++;
    chk_cnt++; if (head_y !== 4'd6) $display("FAIL turn_up_y got %0d want 6", head_y); else pass_cnt++;
  endtask

  task automatic test_growth();
    bit got;
    set_dir(2'b00, 1);
    push_tick();
    await_move(got);
    e = sb.pop_front();
    chk_cnt++; if (!got || {head_x, head_y, snake_length} !== {e.hx, e.hy, e.len})
      $display("FAIL grow_head got (%0d,%0d) len %0d want (%0d,%0d) len %0d", head_x, head_y, snake_length, e.hx, e.hy, e.len);
    else pass_cnt++;
    chk_cnt++; if (snake_length !== 8'd4) $display("FAIL grow_len got %0d want 4", snake_length); else pass_cnt++;
    chk_cnt++; if (x[3] !== 4'd8 || y[3] !== 4'd7) $display("FAIL grow_tail got (%0d,%0d) want (8,7)", x[3], y[3]); else pass_cnt++;
  endtask

  task automatic test_collision();
    strobe(0, 1, 0, 1);
    chk_cnt++; if (alive !== 1'b0 || moved !== 1'b0) $display("FAIL coll_state got alive=%b moved=%b want 0/0", alive, moved); else pass_cnt++;
    chk_cnt++; if (head_x !== mx[0] || head_y !== my[0] || snake_length !== 8'(mlen))
      $display("FAIL coll_hold got (%0d,%0d) len %0d want (%0d,%0d) len %0d", head_x, head_y, snake_length, mx[0], my[0], mlen);
    else pass_cnt++;
    dir = 2'b01;
    strobe(0, 1, 1, 0);
    chk_cnt++; if (head_x !== mx[0] || head_y !== my[0] || snake_length !== 8'(mlen) || moved !== 1'b0)
      $display("FAIL dead_hold got (%0d,%0d) len %0d moved %b want (%0d,%0d) len %0d", head_x, head_y, snake_length, moved, mx[0], my[0], mlen);
    else pass_cnt++;
    strobe(1, 0, 0, 0);
    chk_cnt++; if (alive !== 1'b0 || head_x !== 4'd7 || head_y !== 4'd7 || x[1] !== 4'd6 || snake_length !== 8'd3)
      $display("FAIL restart_init got alive=%b (%0d,%0d) x1=%0d len %0d want 0 (7,7) 6 3", alive, head_x, head_y, x[1], snake_length);
    else pass_cnt++;
    model_init();
    strobe(1, 0, 0, 0);
    chk_cnt++; if (alive !== 1'b1) $display("FAIL restart_run got %b want 1", alive); else pass_cnt++;
  endtask

  task automatic test_edge();
    bit got;
    set_dir(2'b01, 0);
    for (int k = 0; k < 8; k++) begin
      push_tick();
      await_move(got);
      e = sb.pop_front();
      chk_cnt++; if (!got || head_x !== e.hx || head_y !== e.hy)
        $display("FAIL edge_walk%0d got (%0d,%0d) want (%0d,%0d)", k, head_x, head_y, e.hx, e.hy);
      else pass_cnt++;
    end
    strobe(0, 1, 0, 0);
`ifdef SNAKE_WRAP_EN
    chk_cnt++; if (head_x !== 4'd0 || alive !== 1'b1 || moved !== 1'b1)
      $display("FAIL edge_wrap got x=%0d alive=%b moved=%b want 0/1/1", head_x, alive, moved);
    else pass_cnt++;
`else
    chk_cnt++; if (head_x !== 4'd15 || alive !== 1'b0 || moved !== 1'b0)
      $display("FAIL edge_border got x=%0d alive=%b moved=%b want 15/0/0", head_x, alive, moved);
    else pass_cnt++;
`endif
    // Asynchronous reset asserted mid-cycle must take effect without a clock edge.
    #2 rst = 1;
    #1;
    chk_cnt++; if (head_x !== 4'd7 || alive !== 1'b0 || snake_length !== 8'd3)
      $display("FAIL async_rst got x=%0d alive=%b len %0d want 7/0/3", head_x, alive, snake_length);
    else pass_cnt++;
    cyc();
    rst = 0;
    model_init();
    strobe(1, 0, 0, 0);
  endtask

  task automatic test_saturation();
    bit got;
    logic [1:0] seq [0:3];
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b00; seq[3] = 2'b01;
    for (int k = 0; k < 126; k++) begin
      set_dir(seq[k % 4], 1);
      push_tick();
      await_move(got);
      e = sb.pop_front();
      chk_cnt++; if (!got || {head_x, head_y, snake_length} !== {e.hx, e.hy, e.len})
        $display("FAIL sat_step%0d got (%0d,%0d) len %0d want (%0d,%0d) len %0d", k, head_x, head_y, snake_length, e.hx, e.hy, e.len);
      else pass_cnt++;
    end
    chk_cnt++; if (snake_length !== 8'd128) $display("FAIL sat_len got %0d want 128", snake_length); else pass_cnt++;
    chk_cnt++; if (dut.grow_pending !== 1'b0) $display("FAIL sat_pending got %b want 0", dut.grow_pending); else pass_cnt++;
    chk_cnt++; if (sb.size() != 0) $display("FAIL sb_drain got %0d want 0", sb.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_reversal();
    test_growth();
    test_collision();
    test_edge();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
